// File: rtl/anim_pkg.sv
// Shared types and constants for the character animation controller:
// FSM states, sprite_control bit layout, run-cycle length and reset word.
package anim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        JUMP = 2'd2
    } anim_state_t;

    localparam int DIR_BIT    = 6;
    localparam int JUMP_BIT   = 5;
    localparam int IDLE_BIT   = 4;
    localparam int RUN_FRAMES = 8;
    localparam int IDX_W      = $clog2(RUN_FRAMES);

    localparam logic [6:0] RESET_WORD = 7'h50;

    // Prescaler counter width: clog2 of the divide ratio, never below one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/anim_step_div.sv
// frame_tick prescaler: counts enabled ticks and strobes step on every
// FRAMES_PER_STEP-th one; clear restarts the count and suppresses the strobe.
module anim_step_div
    import anim_pkg::*;
#(
    parameter int FRAMES_PER_STEP = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic step
);

    localparam int CW = cnt_width(FRAMES_PER_STEP);
    localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_STEP - 1);

    logic [CW-1:0] cnt;

    assign step = enable && !clear && (cnt == LAST);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= step ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/character_anim_ctl.sv
// Character animation FSM (IDLE/RUN/JUMP) producing a registered sprite selector.
// Optional build macro ANIM_PAUSE_EN adds a pause input that freezes all state.
module character_anim_ctl
    import anim_pkg::*;
#(
    parameter int FRAMES_PER_STEP = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       on_ground,
`ifdef ANIM_PAUSE_EN
    input  logic       pause,
`endif
    output logic [6:0] sprite_control
);

`ifndef ANIM_PAUSE_EN
    logic pause;
    assign pause = 1'b0;
`endif

    anim_state_t      state_q, state_d;
    logic             dir_q, dir_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [6:0]       sprite_d;
    logic             move;
    logic             div_enable, div_clear, div_step;

    anim_step_div #(
        .FRAMES_PER_STEP(FRAMES_PER_STEP)
    ) u_step_div (
        .clk    (clk),
        .rst    (rst),
        .enable (div_enable),
        .clear  (div_clear),
        .step   (div_step)
    );

    // State register; the output word is registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            dir_q          <= 1'b1;
            idx_q          <= '0;
            sprite_control <= RESET_WORD;
        end else if (!pause) begin
            state_q        <= state_d;
            dir_q          <= dir_d;
            idx_q          <= idx_d;
            sprite_control <= sprite_d;
        end
    end

    // Next-state logic: airborne beats movement; both directions cancel.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        state_d = IDLE;
        move    = move_left ^ move_right;
        dir_d   = move ? move_right : dir_q;

        if (!on_ground) begin
            state_d = JUMP;
        end else if (move) begin
            state_d = RUN;
        end

        div_clear  = !pause && (state_d == RUN) && ((state_q != RUN) || (dir_d != dir_q));
        div_enable = !pause && frame_tick && (state_q == RUN) && (state_d == RUN);

        idx_d = idx_q;
        if (div_clear) begin
            idx_d = '0;
        end else if (div_step) begin
            idx_d = idx_q + 1'b1;
        end
    end

    // Output decode from the next state, captured by the register above.
    always_comb begin
        sprite_d          = '0;
        sprite_d[DIR_BIT] = dir_d;
        case (state_d)
            IDLE:    sprite_d[IDLE_BIT]    = 1'b1;
            JUMP:    sprite_d[JUMP_BIT]    = 1'b1;
            RUN:     sprite_d[IDX_W-1:0]   = idx_d;
            default: sprite_d              = RESET_WORD;
        endcase
    end

endmodule

// File: doc/character_anim_ctl.md
CHARACTER_ANIM_CTL -- requirements
Module: character_anim_ctl

Interface
REQ-001 SHALL have parameter FRAMES_PER_STEP, default 4, meaning frame_tick pulses per run-frame advance (legal range 1..255).
REQ-002 SHALL have port clk, input, 1, posedge-active system clock (the only clock).
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port frame_tick, input, 1, single-cycle pulse once per video frame.
REQ-005 SHALL have port move_left, input, 1, player left command (level).
REQ-006 SHALL have port move_right, input, 1, player right command (level).
REQ-007 SHALL have port on_ground, input, 1, character grounded flag; 0 means airborne.
REQ-008 SHALL have port sprite_control, output, 7, registered sprite selector word.
- Bit 6: direction; 1 = right, 0 = left.
- Bit 5: jump.
- Bit 4: idle.
- Bits 3:0: run frame index.

Function
REQ-009 SHALL implement FSM states IDLE, RUN and JUMP, evaluated every clk.
REQ-010 SHALL decode move = move_left XOR move_right; both high SHALL be treated as no move.
REQ-011 SHALL apply transition priority as follows.
- on_ground=0: go to JUMP.
- on_ground=1 and move=1: go to RUN.
- Otherwise: go to IDLE.
REQ-012 SHALL update the direction bit one cycle after a sampled single-direction input, in any state including JUMP; with no move, the direction bit SHALL hold its value.
REQ-013 SHALL drive sprite_control per state as follows.
- IDLE: {dir, 0, 1, 4'b0000}.
- JUMP: {dir, 1, 0, 4'b0000}.
- RUN: {dir, 0, 0, 0, idx[2:0]}.
REQ-014 SHALL keep bit 3 at 0 in all states.
REQ-015 SHALL keep an internal tick counter of width clog2(FRAMES_PER_STEP), minimum 1 bit, incremented only on frame_tick while in RUN.
REQ-016 SHALL, on frame_tick when the tick counter equals FRAMES_PER_STEP-1, clear the tick counter and advance idx by 1 modulo 8 (7 wraps to 0).
REQ-017 SHALL clear idx and the tick counter on entry to RUN, and on a direction change while in RUN.
REQ-018 SHALL give sprite_control exactly 1 clk latency from a sampled input or frame_tick to output.
REQ-019 SHALL give on_ground falling in the same cycle as frame_tick priority to JUMP; idx SHALL NOT advance in that cycle.

Reset
REQ-020 SHALL, while rst=1 at a clk edge, set state=IDLE, dir=1, idx=0, tick counter=0 and sprite_control=7'h50.
REQ-021 SHALL, on reset mid-RUN or mid-JUMP, output 7'h50 on the next cycle regardless of inputs; normal evaluation SHALL resume on the first clk after rst deasserts.

Configuration
REQ-022 SHALL, with macro ANIM_PAUSE_EN defined, add input port pause (1 bit).
- pause=1: sprite_control, state, dir, idx and tick counter all hold.
- frame_tick pulses arriving during pause SHALL be discarded.
- rst overrides pause.
REQ-023 SHALL, without ANIM_PAUSE_EN, have no pause port and behave as if pause=0.

Structure
REQ-024 SHALL place the following in shared package anim_pkg:
- state enum (IDLE, RUN, JUMP);
- sprite_control bit-position constants (DIR_BIT=6, JUMP_BIT=5, IDLE_BIT=4);
- RUN_FRAMES=8;
- reset word 7'h50.
REQ-025 SHALL implement the frame_tick prescaler (tick counter plus advance strobe) as sub-module anim_step_div, with enable and clear inputs.

Verification
REQ-026 SHALL verify reset: assert rst for 3 cycles with move_right=1 and on_ground=0 -> sprite_control=7'h50 throughout, then 7'h60 one cycle after rst drops.
REQ-027 SHALL verify running wrap: on_ground=1, move_right=1, 32 frame_ticks at FRAMES_PER_STEP=4 -> output 7'h40, advancing every 4 ticks through 7'h47, and back to 7'h40 after the 32nd tick.
REQ-028 SHALL verify direction flip: mid-run at idx=5, move_right=0 and move_left=1 -> next cycle 7'h00 with the tick counter cleared.
REQ-029 SHALL verify jump: running left at idx=3 (7'h03), on_ground=0 together with frame_tick -> 7'h20; on_ground=1 with move_left=1 -> 7'h00.
REQ-030 SHALL verify simultaneous inputs: move_left=1 and move_right=1 with on_ground=1 from left-run -> 7'h10, dir unchanged.
REQ-031 SHALL verify pause (ANIM_PAUSE_EN builds): pause=1 for 10 frame_ticks at 7'h42 -> output stays 7'h42; after release, 4 further ticks are required to reach 7'h43.
